tmds_frame_decoder: RTL and testbench

- Receive-side counterpart of the HDMI output path.
- Takes one word-aligned 10-bit TMDS symbol per channel per `hdmi_clk` and decodes it into 8-bit pixel data or control tokens.
- Rebuilds the `hve` sync/enable bundle and the pixel coordinates `x`/`y` in the same format `display_signal` produces.
- Measures the active resolution of each frame.
- Sits between a deserializer/word-aligner and any pixel consumer, such as a loopback checker feeding the `hdmi` transmitter.

---
 rtl/tmds_frame_decoder_pkg.sv | 54 +++++
 rtl/tmds_symbol_decoder.sv | 42 ++++
 rtl/tmds_frame_decoder.sv | 175 +++++++++++++++++
 tb/tb_tmds_frame_decoder.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_frame_decoder_pkg.sv
// Shared TMDS definitions for the receive path (and reused by the transmit encoder):
//   - the four control-period tokens,
//   - the bit positions inside the {hsync, vsync, de} bundle,
//   - the stage-1 symbol record and the combinational symbol classifier/decoder.
package tmds_frame_decoder_pkg;

  // Control-period tokens; the token index is {c1, c0}.
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Bit indices inside the hve bundle.
  localparam int unsigned HVE_H  = 2;
  localparam int unsigned HVE_V  = 1;
  localparam int unsigned HVE_DE = 0;

  // One decoded channel symbol.
  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] c;
    logic [7:0] data;
  } tmds_sym_t;

  // The state a channel is considered to be in straight out of reset: an idle
  // control token, so no phantom data cycle reaches the stage-2 logic.
  localparam tmds_sym_t SYM_IDLE = '{is_ctrl: 1'b1, c: 2'b00, data: 8'h00};

  // Classify a 10-bit symbol as a control token or a data symbol and decode it.
  function automatic tmds_sym_t tmds_classify(input logic [9:0] q);
    tmds_sym_t  s;
    logic [7:0] d;
    s.is_ctrl = 1'b1;
    s.c       = 2'b00;
    s.data    = 8'h00;
    d         = q[9] ? ~q[7:0] : q[7:0];
    case (q)
      CTRL_00: s.c = 2'b00;
      CTRL_01: s.c = 2'b01;
      CTRL_10: s.c = 2'b10;
      CTRL_11: s.c = 2'b11;
      default: begin
        s.is_ctrl = 1'b0;
        s.data[0] = d[0];
        // q[8] selects XOR vs XNOR chaining used by the encoder.
        for (int i = 1; i < 8; i++) begin
          s.data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_symbol_decoder.sv
// Stage 1 of the TMDS receive pipeline for one channel.
// Classifies the incoming 10-bit symbol and registers {is_ctrl, c, data}.
// Ports:
//   hdmi_clk   pixel clock
//   reset      synchronous, active-high
//   i_sym      word-aligned 10-bit TMDS symbol
//   o_is_ctrl  1 = control token, 0 = data symbol
//   o_c        control token index {c1, c0} (0 for data)
//   o_data     decoded 8-bit data (0 for control)
module tmds_symbol_decoder
  import tmds_frame_decoder_pkg::*;
(
  input  logic       hdmi_clk,
  input  logic       reset,
  input  logic [9:0] i_sym,
  output logic       o_is_ctrl,
  output logic [1:0] o_c,
  output logic [7:0] o_data
);

  tmds_sym_t sym_d;
  tmds_sym_t sym_q;

  always_comb begin
    sym_d = tmds_classify(i_sym);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      sym_q <= SYM_IDLE;
    end else begin
      sym_q <= sym_d;
    end
  end

  assign o_is_ctrl = sym_q.is_ctrl;
  assign o_c       = sym_q.c;
  assign o_data    = sym_q.data;

endmodule

// File: rtl/tmds_frame_decoder.sv
// TMDS frame decoder: turns three word-aligned TMDS symbol streams into pixel
// data plus the {hsync, vsync, de} bundle, pixel coordinates and per-frame
// active-resolution measurement. Two-cycle latency, all outputs registered.
// Ports:
//   hdmi_clk       pixel clock, one symbol per channel per cycle
//   reset          synchronous, active-high
//   i_ch0/1/2      blue/green/red 10-bit symbols (ch0 carries hsync/vsync)
//   o_hve          {hsync, vsync, de}
//   o_rgb          {red, green, blue}; zero outside DE and on error cycles
//   o_x, o_y       signed pixel / line index, -1 when not applicable
//   o_frame_start  pulse on the first cycle vsync is high
//   o_width        pixel count of the last completed active line
//   o_height       active line count of the last completed frame
//   o_err          pulse on a cross-channel symbol inconsistency
module tmds_frame_decoder #(
  parameter int COORD_W = 13
) (
  input  logic                      hdmi_clk,
  input  logic                      reset,
  input  logic [9:0]                i_ch0,
  input  logic [9:0]                i_ch1,
  input  logic [9:0]                i_ch2,
  output logic [2:0]                o_hve,
  output logic [23:0]               o_rgb,
  output logic signed [COORD_W-1:0] o_x,
  output logic signed [COORD_W-1:0] o_y,
  output logic                      o_frame_start,
  output logic [COORD_W-1:0]        o_width,
  output logic [COORD_W-1:0]        o_height,
  output logic                      o_err
);

  import tmds_frame_decoder_pkg::*;

  localparam logic signed [COORD_W-1:0] ONE       = COORD_W'(1);
  localparam logic signed [COORD_W-1:0] MINUS_ONE = '1;

  // ---------------- Stage 1: per-channel classify/decode ----------------
  tmds_sym_t s0;
  tmds_sym_t s1;
  tmds_sym_t s2;

  tmds_symbol_decoder u_dec_ch0 (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .i_sym    (i_ch0),
    .o_is_ctrl(s0.is_ctrl),
    .o_c      (s0.c),
    .o_data   (s0.data)
  );

  tmds_symbol_decoder u_dec_ch1 (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .i_sym    (i_ch1),
    .o_is_ctrl(s1.is_ctrl),
    .o_c      (s1.c),
    .o_data   (s1.data)
  );

  tmds_symbol_decoder u_dec_ch2 (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .i_sym    (i_ch2),
    .o_is_ctrl(s2.is_ctrl),
    .o_c      (s2.c),
    .o_data   (s2.data)
  );

  // ---------------- Stage 2: error, hve, coordinates, measurement -------
  logic [2:0]                hve_d,         hve_q;
  logic [23:0]               rgb_d,         rgb_q;
  logic signed [COORD_W-1:0] x_d,           x_q;
  logic signed [COORD_W-1:0] y_d,           y_q;
  logic                      frame_start_d, frame_start_q;
  logic [COORD_W-1:0]        width_d,       width_q;
  logic [COORD_W-1:0]        height_d,      height_q;
  logic                      err_d,         err_q;

  logic de_n;
  logic de_rise;
  logic de_fall;
  logic vsync_rise;

  // The registered hve bundle doubles as the edge-detect history: hve_q is
  // exactly the previous cycle's de/vsync as seen by this stage.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hve_d         = hve_q;
    rgb_d         = 24'h000000;
    x_d           = MINUS_ONE;
    y_d           = y_q;
    width_d       = width_q;
    height_d      = height_q;
    err_d         = 1'b0;
    frame_start_d = 1'b0;

    de_n = ~s0.is_ctrl;

    // Sync bits only change in control periods; during DE they hold.
    hve_d[HVE_DE] = de_n;
    if (!de_n) begin
      hve_d[HVE_H] = s0.c[0];
      hve_d[HVE_V] = s0.c[1];
    end

    de_rise    = de_n & ~hve_q[HVE_DE];
    de_fall    = ~de_n & hve_q[HVE_DE];
    vsync_rise = hve_d[HVE_V] & ~hve_q[HVE_V];

    // Green/red must agree with blue on class, and in control periods they
    // carry no information, so only token 00 is legal there.
    err_d = (s1.is_ctrl != s0.is_ctrl) || (s2.is_ctrl != s0.is_ctrl) ||
            (s0.is_ctrl && ((s1.c != 2'b00) || (s2.c != 2'b00)));

    if (de_n && !err_d) begin
      rgb_d = {s2.data, s1.data, s0.data};
    end

    if (de_n) begin
      x_d = hve_q[HVE_DE] ? x_q + ONE : '0;
    end

    // vsync and a DE rise can never coincide: vsync only moves in control.
    if (vsync_rise) begin
      y_d = MINUS_ONE;
    end else if (de_rise) begin
      y_d = y_q + ONE;
    end

    if (de_fall) begin
      width_d = x_q + ONE;
    end

    // A frame with no active lines still has y = -1 here and is ignored.
    if (vsync_rise && !y_q[COORD_W-1]) begin
      height_d = y_q + ONE;
    end

    frame_start_d = vsync_rise;
  end

  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      hve_q         <= 3'b000;
      rgb_q         <= 24'h000000;
      x_q           <= MINUS_ONE;
      y_q           <= MINUS_ONE;
      frame_start_q <= 1'b0;
      width_q       <= '0;
      height_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      hve_q         <= hve_d;
      rgb_q         <= rgb_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      width_q       <= width_d;
      height_q      <= height_d;
      err_q         <= err_d;
    end
  end

  assign o_hve         = hve_q;
  assign o_rgb         = rgb_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame_start = frame_start_q;
  assign o_width       = width_q;
  assign o_height      = height_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_tmds_frame_decoder.sv
// Scoreboard bench for tmds_frame_decoder: each driven symbol triple pushes an
// expected output record; the record is popped and compared two cycles later.
module tb_tmds_frame_decoder;

  localparam int CW = 13;
  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic signed [CW-1:0] S1  = 1;
  localparam logic signed [CW-1:0] SM1 = -1;

  logic                 hdmi_clk = 1'b0;
  logic                 reset    = 1'b1;
  logic [9:0]           i_ch0    = T00;
  logic [9:0]           i_ch1    = T00;
  logic [9:0]           i_ch2    = T00;
  logic [2:0]           o_hve;
  logic [23:0]          o_rgb;
  logic signed [CW-1:0] o_x;
  logic signed [CW-1:0] o_y;
  logic                 o_frame_start;
  logic [CW-1:0]        o_width;
  logic [CW-1:0]        o_height;
  logic                 o_err;

  tmds_frame_decoder #(.COORD_W(CW)) dut (
    .hdmi_clk     (hdmi_clk),
    .reset        (reset),
    .i_ch0        (i_ch0),
    .i_ch1        (i_ch1),
    .i_ch2        (i_ch2),
    .o_hve        (o_hve),
    .o_rgb        (o_rgb),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_frame_start(o_frame_start),
    .o_width      (o_width),
    .o_height     (o_height),
    .o_err        (o_err)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  typedef struct {
    logic [2:0]           hve;
    logic [23:0]          rgb;
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
    logic                 fs;
    logic [CW-1:0]        w;
    logic [CW-1:0]        ht;
    logic                 err;
  } exp_t;

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] c;
  } stim_t;

  exp_t  sb_q[$];
  stim_t plan[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model state: the previous output values.
  logic                 m_h, m_v, m_de;
  logic signed [CW-1:0] m_x, m_y;
  logic [CW-1:0]        m_w, m_ht;

  // {is_ctrl, c1, c0}
  function automatic logic [2:0] tok(input logic [9:0] q);
    case (q)
      T00:     return 3'b100;
      T01:     return 3'b101;
      T10:     return 3'b110;
      T11:     return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] q);
    logic [7:0] d, r;
    d    = q[9] ? ~q[7:0] : q[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++) r[i] = ~(d[i] ^ d[i-1] ^ q[8]);
    return r;
  endfunction

  // Encoder inverse of the decode rule, used to build data symbols from bytes.
  function automatic logic [9:0] enc(input logic [7:0] b, input logic q8, input logic q9);
    logic [7:0] d;
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = b[i] ^ d[i-1] ^ ~q8;
    return {q9, q8, (q9 ? ~d : d)};
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    logic [2:0] t;
    do begin
      s = enc(8'($urandom), 1'($urandom), 1'($urandom));
      t = tok(s);
    end while (t[2]);
    return s;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_de = 0; m_x = SM1; m_y = SM1; m_w = '0; m_ht = '0;
  endtask

  task automatic model_apply(input logic [9:0] a, b, c, output exp_t e);
    logic [2:0] t0, t1, t2;
    logic de, h, v, vr;
    t0 = tok(a); t1 = tok(b); t2 = tok(c);
    de    = ~t0[2];
    h     = de ? m_h : t0[0];
    v     = de ? m_v : t0[1];
    e.err = (t1[2] != t0[2]) || (t2[2] != t0[2]) ||
            (t0[2] && (t1[1:0] != 2'b00 || t2[1:0] != 2'b00));
    e.rgb = (de && !e.err) ? {dec(c), dec(b), dec(a)} : 24'h0;
    e.hve = {h, v, de};
    e.x   = de ? (m_de ? m_x + S1 : '0) : SM1;
    vr    = v && !m_v;
    e.y   = vr ? SM1 : ((de && !m_de) ? m_y + S1 : m_y);
    e.w   = (!de && m_de) ? CW'(m_x + S1) : m_w;
    e.ht  = (vr && m_y >= 0) ? CW'(m_y + S1) : m_ht;
    e.fs  = vr;
    m_h = h; m_v = v; m_de = de; m_x = e.x; m_y = e.y; m_w = e.w; m_ht = e.ht;
  endtask

  // Drive one symbol triple, push its expectation, advance one clock and pop
  // the expectation that belongs to the outputs now visible.
  task automatic step(input logic [9:0] a, b, c, output exp_t e);
    exp_t n;
    i_ch0 = a; i_ch1 = b; i_ch2 = c;
    model_apply(a, b, c, n);
    sb_q.push_back(n);
    @(posedge hdmi_clk);
    #1;
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
    end else begin
      checks++; failures++;
      $display("FAIL scoreboard_underflow: got size %0d required >=2", sb_q.size());
      e = n;
    end
  endtask

  // After reset the stage-1 registers hold an idle token; model that entry.
  task automatic do_reset();
    exp_t e;
    i_ch0 = T00; i_ch1 = T00; i_ch2 = T00;
    reset = 1'b1;
    @(posedge hdmi_clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    model_reset();
    model_apply(T00, T00, T00, e);
    sb_q.push_back(e);
  endtask

  task automatic plan_add(input logic [9:0] a, b, c, input int n);
    stim_t s;
    s.a = a; s.b = b; s.c = c;
    repeat (n) plan.push_back(s);
  endtask

  task automatic plan_line(input int npix);
    plan_add(T01, T00, T00, 2);
    plan_add(T00, T00, T00, 2);
    for (int i = 0; i < npix; i++) plan_add(rand_data(), rand_data(), rand_data(), 1);
    plan_add(T00, T00, T00, 2);
  endtask

  task automatic plan_vsync();
    plan_add(T10, T00, T00, 3);
    plan_add(T00, T00, T00, 2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_hve !== 3'b000) begin failures++; $display("FAIL reset_hve: got %b required 000", o_hve); end
    checks++; if (o_rgb !== 24'h0) begin failures++; $display("FAIL reset_rgb: got %h required 0", o_rgb); end
    checks++; if (o_x !== SM1) begin failures++; $display("FAIL reset_x: got %0d required -1", o_x); end
    checks++; if (o_y !== SM1) begin failures++; $display("FAIL reset_y: got %0d required -1", o_y); end
    checks++; if (o_frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs: got %b required 0", o_frame_start); end
    checks++; if (o_width !== '0) begin failures++; $display("FAIL reset_width: got %0d required 0", o_width); end
    checks++; if (o_height !== '0) begin failures++; $display("FAIL reset_height: got %0d required 0", o_height); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", o_err); end
  endtask

  task automatic test_data_decode();
    logic [9:0]  sym_tab [3];
    logic [7:0]  blue_tab[3];
    logic [23:0] byte_q[$];
    logic [7:0]  r, g, b;
    logic [9:0]  sr, sg, sb;
    logic [2:0]  t;
    exp_t e;
    sym_tab  = '{10'h100, 10'h1FF, 10'h2FF};
    blue_tab = '{8'h00, 8'h01, 8'hFE};
    for (int k = 0; k < 4; k++) begin
      if (k < 3) step(sym_tab[k], 10'h100, 10'h100, e);
      else       step(T00, T00, T00, e);
      if (k >= 1) begin
        checks++;
        if (o_rgb[7:0] !== blue_tab[k-1]) begin
          failures++; $display("FAIL decode_blue_%0d: got %h required %h", k-1, o_rgb[7:0], blue_tab[k-1]);
        end
        checks++;
        if (o_hve !== e.hve || o_rgb !== e.rgb) begin
          failures++; $display("FAIL decode_word_%0d: got hve=%b rgb=%h required hve=%b rgb=%h", k-1, o_hve, o_rgb, e.hve, e.rgb);
        end
      end
    end
    // Random bytes encoded with randomly chosen q8/q9 must come back intact.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        do begin
          r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
          sr = enc(r, 1'($urandom), 1'($urandom));
          sg = enc(g, 1'($urandom), 1'($urandom));
          sb = enc(b, 1'($urandom), 1'($urandom));
          t  = tok(sr) | tok(sg) | tok(sb);
        end while (t[2]);
        byte_q.push_back({r, g, b});
        step(sb, sg, sr, e);
      end else begin
        step(T00, T00, T00, e);
      end
      if (i >= 1) begin
        checks++;
        if (o_rgb !== byte_q[0]) begin
          failures++; $display("FAIL decode_random_%0d: got %h required %h", i-1, o_rgb, byte_q[0]);
        end
        void'(byte_q.pop_front());
      end
    end
  endtask

  task automatic test_control();
    logic [9:0] seq[3];
    logic [2:0] hve_tab[3];
    exp_t e;
    seq     = '{T10, T01, T00};
    hve_tab = '{3'b010, 3'b100, 3'b000};
    for (int k = 0; k < 3; k++) begin
      step(seq[k], T00, T00, e);
      if (k >= 1) begin
        checks++;
        if (o_hve !== hve_tab[k-1] || o_rgb !== 24'h0 || o_err !== 1'b0) begin
          failures++;
          $display("FAIL control_%0d: got hve=%b rgb=%h err=%b required hve=%b rgb=0 err=0", k-1, o_hve, o_rgb, o_err, hve_tab[k-1]);
        end
        checks++;
        if (o_hve !== e.hve) begin
          failures++; $display("FAIL control_sb_%0d: got hve=%b required %b", k-1, o_hve, e.hve);
        end
      end
    end
  endtask

  task automatic test_frame();
    stim_t s;
    exp_t  e;
    int    fs_cnt = 0;
    int    max_x  = -1;
    int    n      = 0;
    plan.delete();
    plan_vsync();
    for (int l = 0; l < 4; l++) plan_line(8);
    plan_vsync();
    while (plan.size() > 0) begin
      s = plan.pop_front();
      step(s.a, s.b, s.c, e);
      n++;
      checks++;
      if (o_x !== e.x || o_y !== e.y || o_hve !== e.hve || o_frame_start !== e.fs ||
          o_width !== e.w || o_height !== e.ht) begin
        failures++;
        $display("FAIL frame_cyc%0d: got x=%0d y=%0d hve=%b fs=%b w=%0d h=%0d required x=%0d y=%0d hve=%b fs=%b w=%0d h=%0d",
                 n, o_x, o_y, o_hve, o_frame_start, o_width, o_height, e.x, e.y, e.hve, e.fs, e.w, e.ht);
      end
      if (o_frame_start === 1'b1) fs_cnt++;
      if (o_hve[0] === 1'b1 && int'(o_x) > max_x) max_x = int'(o_x);
    end
    checks++; if (max_x != 7) begin failures++; $display("FAIL frame_max_x: got %0d required 7", max_x); end
    checks++; if (fs_cnt != 2) begin failures++; $display("FAIL frame_fs_count: got %0d required 2", fs_cnt); end
    checks++; if (o_width !== CW'(8)) begin failures++; $display("FAIL frame_width: got %0d required 8", o_width); end
    checks++; if (o_height !== CW'(4)) begin failures++; $display("FAIL frame_height: got %0d required 4", o_height); end
    checks++; if (o_y !== SM1) begin failures++; $display("FAIL frame_y_after_vsync: got %0d required -1", o_y); end
  endtask

  task automatic test_error();
    stim_t s;
    exp_t  e;
    int    err_cnt = 0;
    int    n       = 0;
    plan.delete();
    plan_add(T01, T00, T00, 2);
    plan_add(T00, T00, T00, 2);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) plan_add(rand_data(), rand_data(), 10'h354, 1);
      else        plan_add(rand_data(), rand_data(), rand_data(), 1);
    end
    plan_add(T00, T00, T00, 2);
    plan_add(T00, T11, T00, 1);
    plan_add(T00, T00, T00, 2);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      step(s.a, s.b, s.c, e);
      n++;
      checks++;
      if (o_err !== e.err || o_rgb !== e.rgb || o_hve !== e.hve || o_x !== e.x) begin
        failures++;
        $display("FAIL error_cyc%0d: got err=%b rgb=%h hve=%b x=%0d required err=%b rgb=%h hve=%b x=%0d",
                 n, o_err, o_rgb, o_hve, o_x, e.err, e.rgb, e.hve, e.x);
      end
      if (o_err === 1'b1) err_cnt++;
      if (e.err && e.hve[0]) begin
        checks++;
        if (o_rgb !== 24'h0 || o_hve[0] !== 1'b1 || o_x !== S1 + S1) begin
          failures++; $display("FAIL error_pixel: got rgb=%h de=%b x=%0d required rgb=0 de=1 x=2", o_rgb, o_hve[0], o_x);
        end
      end
    end
    checks++; if (err_cnt != 2) begin failures++; $display("FAIL error_pulse_count: got %0d required 2", err_cnt); end
  endtask

  task automatic test_reset_midline();
    stim_t s;
    exp_t  e;
    bit    first_de = 1'b1;
    plan.delete();
    plan_vsync();
    plan_line(8);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      step(s.a, s.b, s.c, e);
      if (e.hve[0] && e.x == 3) break;
    end
    checks++; if (o_x !== 3) begin failures++; $display("FAIL midline_x_before_reset: got %0d required 3", o_x); end
    plan.delete();
    do_reset();
    checks++;
    if (o_hve !== 3'b000 || o_rgb !== 24'h0 || o_x !== SM1 || o_y !== SM1 ||
        o_width !== '0 || o_height !== '0 || o_frame_start !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL midline_reset_values: got hve=%b rgb=%h x=%0d y=%0d w=%0d h=%0d fs=%b err=%b required all reset",
               o_hve, o_rgb, o_x, o_y, o_width, o_height, o_frame_start, o_err);
    end
    plan_add(T00, T00, T00, 3);
    plan_line(5);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      step(s.a, s.b, s.c, e);
      checks++;
      if (o_x !== e.x || o_y !== e.y || o_hve !== e.hve || o_width !== e.w || o_height !== e.ht) begin
        failures++;
        $display("FAIL midline_sb: got x=%0d y=%0d hve=%b w=%0d h=%0d required x=%0d y=%0d hve=%b w=%0d h=%0d",
                 o_x, o_y, o_hve, o_width, o_height, e.x, e.y, e.hve, e.w, e.ht);
      end
      if (first_de && o_hve[0] === 1'b1) begin
        first_de = 1'b0;
        checks++;
        if (o_x !== '0 || o_y !== '0) begin
          failures++; $display("FAIL midline_first_de: got x=%0d y=%0d required x=0 y=0", o_x, o_y);
        end
      end
    end
    checks++; if (o_width !== CW'(5)) begin failures++; $display("FAIL midline_width: got %0d required 5", o_width); end
    checks++; if (o_height !== '0) begin failures++; $display("FAIL midline_height_held: got %0d required 0", o_height); end
    plan_vsync();
    while (plan.size() > 0) begin
      s = plan.pop_front();
      step(s.a, s.b, s.c, e);
      checks++;
      if (o_height !== e.ht || o_frame_start !== e.fs) begin
        failures++; $display("FAIL midline_vsync_sb: got h=%0d fs=%b required h=%0d fs=%b", o_height, o_frame_start, e.ht, e.fs);
      end
    end
    checks++; if (o_height !== CW'(1)) begin failures++; $display("FAIL midline_height: got %0d required 1", o_height); end
  endtask

  task automatic test_back_to_back();
    stim_t         s;
    exp_t          e;
    int            fs_cnt = 0;
    logic [CW-1:0] ht_at_fs[4];
    plan.delete();
    plan_vsync();
    for (int l = 0; l < 2; l++) plan_line(6);
    plan_vsync();
    plan_add(T00, T00, T00, 4);
    plan_vsync();
    for (int l = 0; l < 3; l++) plan_line(3);
    plan_vsync();
    while (plan.size() > 0) begin
      s = plan.pop_front();
      step(s.a, s.b, s.c, e);
      checks++;
      if (o_frame_start !== e.fs || o_height !== e.ht || o_y !== e.y || o_width !== e.w) begin
        failures++;
        $display("FAIL b2b_sb: got fs=%b h=%0d y=%0d w=%0d required fs=%b h=%0d y=%0d w=%0d",
                 o_frame_start, o_height, o_y, o_width, e.fs, e.ht, e.y, e.w);
      end
      if (o_frame_start === 1'b1) begin
        if (fs_cnt < 4) ht_at_fs[fs_cnt] = o_height;
        fs_cnt++;
      end
    end
    checks++;
    if (fs_cnt != 4) begin
      failures++; $display("FAIL b2b_fs_count: got %0d required 4", fs_cnt);
    end else begin
      checks++; if (ht_at_fs[1] !== CW'(2)) begin failures++; $display("FAIL b2b_height_f1: got %0d required 2", ht_at_fs[1]); end
      checks++; if (ht_at_fs[2] !== CW'(2)) begin failures++; $display("FAIL b2b_height_empty: got %0d required 2", ht_at_fs[2]); end
      checks++; if (ht_at_fs[3] !== CW'(3)) begin failures++; $display("FAIL b2b_height_f3: got %0d required 3", ht_at_fs[3]); end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge hdmi_clk);
    #1;
    test_reset();
    test_data_decode();
    test_control();
    test_frame();
    test_error();
    test_reset_midline();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
